// File: rtl/mux21_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux21_rr_arbiter
// Description : Two-requester round-robin arbiter driving a shared 2:1 data
//               mux. Requester X owns the mux while s=1, requester Y while
//               s=0. A requester may hold the mux for at most MAX_HOLD
//               consecutive cycles while the other side is waiting; with no
//               competition the grant is held indefinitely. The selected data
//               is registered onto m one cycle after the grant, qualified by
//               m_valid.
// Ports       : clk      - system clock, rising-edge active
//               reset    - synchronous active-high reset
//               req_x    - requester X wants the mux
//               req_y    - requester Y wants the mux
//               x, y     - requester data (WIDTH bits)
//               s        - registered mux select (1 = x, 0 = y)
//               gnt_x    - registered grant to X
//               gnt_y    - registered grant to Y
//               m        - registered muxed data (WIDTH bits)
//               m_valid  - m holds data sampled from a granted requester
//               busy     - arbiter is not idle
// Parameters  : WIDTH    - data width (default 2)
//               MAX_HOLD - max consecutive grants under contention, 1..15
// Revision    : 1.0 - initial release
// ============================================================================
module mux21_rr_arbiter #(
    parameter int WIDTH    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_x,
    input  logic             req_y,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             s,
    output logic             gnt_x,
    output logic             gnt_y,
    output logic [WIDTH-1:0] m,
    output logic             m_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_X = 2'd1,
        ST_GNT_Y = 2'd2
    } state_t;

    // Counter value at which a contested grant must rotate. Four bits cover
    // the full legal MAX_HOLD range of 1..15.
    localparam logic [3:0] c_hold_last = 4'(MAX_HOLD - 1);

    state_t     r_state;
    logic [3:0] r_hold_cnt;
    logic       r_last_x;     // 1 = X was the last side to leave a grant

    state_t     w_next_state;
    logic [3:0] w_next_hold;
    logic [3:0] w_hold_step;  // increment that saturates at c_hold_last

    assign w_hold_step = (r_hold_cnt == c_hold_last) ? r_hold_cnt
                                                     : r_hold_cnt + 4'd1;

    always_comb begin
        w_next_state = r_state;
        w_next_hold  = r_hold_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req_x && req_y) begin
                    // Tie goes to whichever side was not served last.
                    w_next_state = r_last_x ? ST_GNT_Y : ST_GNT_X;
                end else if (req_x) begin
                    w_next_state = ST_GNT_X;
                end else if (req_y) begin
                    w_next_state = ST_GNT_Y;
                end
            end
            ST_GNT_X: begin
                if (!req_x) begin
                    w_next_state = req_y ? ST_GNT_Y : ST_IDLE;
                end else if (req_y && (r_hold_cnt == c_hold_last)) begin
                    w_next_state = ST_GNT_Y;
                end else begin
                    // Uncontested holds saturate rather than wrap so that a
                    // late competitor is served promptly once it appears.
                    w_next_hold = w_hold_step;
                end
            end
            ST_GNT_Y: begin
                if (!req_y) begin
                    w_next_state = req_x ? ST_GNT_X : ST_IDLE;
                end else if (req_x && (r_hold_cnt == c_hold_last)) begin
                    w_next_state = ST_GNT_X;
                end else begin
                    w_next_hold = w_hold_step;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (w_next_state != r_state) begin
            w_next_hold = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 4'd0;
            r_last_x   <= 1'b0;          // Y counts as last served: X wins first tie
            s          <= 1'b0;
            gnt_x      <= 1'b0;
            gnt_y      <= 1'b0;
            m          <= '0;
            m_valid    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_hold_cnt <= w_next_hold;

            if ((r_state == ST_GNT_X) && (w_next_state != ST_GNT_X)) begin
                r_last_x <= 1'b1;
            end else if ((r_state == ST_GNT_Y) && (w_next_state != ST_GNT_Y)) begin
                r_last_x <= 1'b0;
            end

            gnt_x <= (w_next_state == ST_GNT_X);
            gnt_y <= (w_next_state == ST_GNT_Y);
            busy  <= (w_next_state != ST_IDLE);

            // Select keeps its last value while idle.
            if (w_next_state == ST_GNT_X) begin
                s <= 1'b1;
            end else if (w_next_state == ST_GNT_Y) begin
                s <= 1'b0;
            end

            // Data path follows the grant that is visible during this cycle,
            // so m lags the grant by one clock.
            if (gnt_x) begin
                m       <= x;
                m_valid <= 1'b1;
            end else if (gnt_y) begin
                m       <= y;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux21_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux21_rr_arbiter
// Description : Self-checking bench for mux21_rr_arbiter. Directed scenarios
//               plus randomized traffic compared cycle by cycle against a
//               behavioural model that tracks the owner of the mux and how
//               many cycles it has held it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux21_rr_arbiter;

    localparam int WIDTH    = 2;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_x = 1'b0;
    logic             req_y = 1'b0;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             s;
    logic             gnt_x;
    logic             gnt_y;
    logic [WIDTH-1:0] m;
    logic             m_valid;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: owner 0 = nobody, 1 = X, 2 = Y.
    int               mdl_owner  = 0;
    int               mdl_held   = 0;   // cycles the current owner has been granted
    bit               mdl_last_x = 1'b0;
    bit               mdl_s      = 1'b0;
    logic [WIDTH-1:0] mdl_m      = '0;
    bit               mdl_valid  = 1'b0;

    mux21_rr_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req_x   (req_x),
        .req_y   (req_y),
        .x       (x),
        .y       (y),
        .s       (s),
        .gnt_x   (gnt_x),
        .gnt_y   (gnt_y),
        .m       (m),
        .m_valid (m_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge(input bit rst, input bit rx, input bit ry,
                              input logic [WIDTH-1:0] xd, input logic [WIDTH-1:0] yd);
        int nxt;
        if (rst) begin
            mdl_owner = 0; mdl_held = 0; mdl_last_x = 1'b0;
            mdl_s = 1'b0; mdl_m = '0; mdl_valid = 1'b0;
            return;
        end
        if (mdl_owner == 1) begin
            mdl_m = xd; mdl_valid = 1'b1;
        end else if (mdl_owner == 2) begin
            mdl_m = yd; mdl_valid = 1'b1;
        end else begin
            mdl_valid = 1'b0;
        end
        nxt = mdl_owner;
        if (mdl_owner == 0) begin
            if (rx && ry)  nxt = mdl_last_x ? 2 : 1;
            else if (rx)   nxt = 1;
            else if (ry)   nxt = 2;
        end else begin
            bit mine  = (mdl_owner == 1) ? rx : ry;
            bit other = (mdl_owner == 1) ? ry : rx;
            int oside = (mdl_owner == 1) ? 2 : 1;
            if (!mine)                            nxt = other ? oside : 0;
            else if (other && mdl_held >= MAX_HOLD) nxt = oside;
        end
        if (nxt != mdl_owner) begin
            if (mdl_owner != 0) mdl_last_x = (mdl_owner == 1);
            mdl_held = (nxt != 0) ? 1 : 0;
        end else if (nxt != 0) begin
            mdl_held++;
        end
        mdl_owner = nxt;
        if (nxt == 1) mdl_s = 1'b1;
        else if (nxt == 2) mdl_s = 1'b0;
    endtask

    // Drive one cycle of inputs, clock it, then compare DUT against model.
    task automatic cycle(input bit rst, input bit rx, input bit ry,
                         input logic [WIDTH-1:0] xd, input logic [WIDTH-1:0] yd);
        @(negedge clk);
        reset = rst; req_x = rx; req_y = ry; x = xd; y = yd;
        model_edge(rst, rx, ry, xd, yd);
        @(posedge clk);
        #1;
        chk("outs", {25'd0, s, gnt_x, gnt_y, m, m_valid, busy},
            {25'd0, mdl_s, mdl_owner == 1, mdl_owner == 2, mdl_m, mdl_valid, mdl_owner != 0});
        chk("excl", {31'd0, gnt_x & gnt_y}, 32'd0);
    endtask

    initial begin
        // Reset held two cycles with X requesting.
        cycle(1, 1, 0, 2'b11, 2'b11);
        cycle(1, 1, 0, 2'b11, 2'b11);
        chk("rst_outs", {25'd0, s, gnt_x, gnt_y, m, m_valid, busy}, 32'd0);

        // Single requester holds forever.
        cycle(0, 1, 0, 2'b10, 2'b00);
        chk("single_gnt", {30'd0, gnt_x, s}, 32'd3);
        cycle(0, 1, 0, 2'b10, 2'b00);
        chk("single_m", {29'd0, m, m_valid}, {29'd0, 2'b10, 1'b1});
        for (int i = 0; i < 20; i++) cycle(0, 1, 0, 2'b10, 2'b00);
        chk("single_hold", {31'd0, gnt_x}, 32'd1);

        // Tie from reset: X x4, Y x4, ...
        cycle(1, 0, 0, 2'b00, 2'b00);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 1, 2'b01, 2'b11);
            chk("tie_gx", {31'd0, gnt_x}, {31'd0, ((i / 4) % 2) == 0});
            if (i > 0)
                chk("tie_m", {29'd0, m, m_valid},
                    {29'd0, (((i - 1) / 4) % 2 == 0) ? 2'b01 : 2'b11, 1'b1});
        end

        // Early release then both drop.
        cycle(1, 0, 0, 2'b00, 2'b00);
        cycle(0, 1, 0, 2'b10, 2'b01);
        cycle(0, 1, 1, 2'b10, 2'b01);
        cycle(0, 0, 1, 2'b10, 2'b01);
        chk("early_gy", {29'd0, gnt_x, gnt_y, busy}, 32'd3);
        cycle(0, 0, 1, 2'b10, 2'b01);
        cycle(0, 0, 0, 2'b10, 2'b01);
        chk("drop_idle", {30'd0, gnt_y, busy}, 32'd0);
        cycle(0, 0, 0, 2'b10, 2'b10);
        chk("drop_m", {29'd0, m, m_valid}, {29'd0, 2'b01, 1'b0});

        // Reset mid-grant.
        cycle(1, 0, 0, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 2'b01, 2'b10);
        cycle(1, 1, 1, 2'b01, 2'b10);
        chk("midrst", {25'd0, s, gnt_x, gnt_y, m, m_valid, busy}, 32'd0);
        cycle(0, 1, 1, 2'b01, 2'b10);
        chk("midrst_first", {30'd0, gnt_x, gnt_y}, 32'd2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0),
                  WIDTH'($urandom), WIDTH'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
